// File: rtl/xs3_pkg.sv
// Shared definitions for the excess-3 (XS3) decode path: code limits,
// offset and the sequencer state encoding.
package xs3_pkg;

    localparam logic [3:0] XS3_OFFSET = 4'd3;
    localparam logic [3:0] XS3_MIN    = 4'b0011;
    localparam logic [3:0] XS3_MAX    = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } xs3_state_t;

    // True when a 4-bit code lies inside the legal XS3 range 3..12.
    function automatic logic xs3_is_legal(input logic [3:0] code);
        return (code >= XS3_MIN) && (code <= XS3_MAX);
    endfunction

endpackage

// File: rtl/xs3_digit_dec.sv
// Single-digit XS3 -> BCD decoder. Purely combinational so it can be
// time-shared by the sequential decoder or replicated by a parallel one.
module xs3_digit_dec
    import xs3_pkg::*;
(
    input  logic [3:0] i_xs3,
    output logic [3:0] o_bcd,
    output logic       o_invalid
);

    // Subtract the offset for legal codes; illegal codes decode to zero.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_bcd     = 4'd0;
        o_invalid = 1'b1;
        if (xs3_is_legal(i_xs3)) begin
            o_bcd     = i_xs3 - XS3_OFFSET;
            o_invalid = 1'b0;
        end
    end

endmodule

// File: rtl/xs3_bcd_seq_dec.sv
// Sequential multi-digit XS3 -> BCD decoder. Accepts a word on a
// valid/ready input, decodes one digit per clock (LSD first) and presents
// the BCD word plus a per-digit error mask on a valid/ready output.
module xs3_bcd_seq_dec
    import xs3_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_xs3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_err,
    output logic [DIGITS-1:0]     err_mask,
    output logic                  busy
);

    localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);

    xs3_state_t           r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [4*DIGITS-1:0]  r_xs3;
    logic [4*DIGITS-1:0]  r_bcd;
    logic [DIGITS-1:0]    r_err_mask;

    logic [3:0]           w_digit;
    logic [3:0]           w_bcd;
    logic                 w_invalid;
    logic                 w_accept;

    // The digit currently being decoded, selected from the latched word.
    assign w_digit  = r_xs3[r_idx*4 +: 4];

    // Input handshake is only offered in IDLE and never during reset.
    assign in_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept = in_valid && in_ready;

    xs3_digit_dec u_digit_dec (
        .i_xs3     (w_digit),
        .o_bcd     (w_bcd),
        .o_invalid (w_invalid)
    );

    // Sequencer: accept a word, walk its digits, then hold the result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_xs3      <= '0;
            r_bcd      <= '0;
            r_err_mask <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_xs3      <= in_xs3;
                        r_bcd      <= '0;
                        r_err_mask <= '0;
                        r_idx      <= '0;
                        r_state    <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    r_bcd[r_idx*4 +: 4] <= w_bcd;
                    r_err_mask[r_idx]   <= w_invalid;
                    if (r_idx == LAST_IDX) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_CONV) || (r_state == ST_DONE);
    assign out_bcd   = r_bcd;
    assign err_mask  = r_err_mask;
    assign out_err   = |r_err_mask;

endmodule

// File: tb/tb_xs3_bcd_seq_dec.sv
// Directed bench for xs3_bcd_seq_dec with DIGITS=4. Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
module tb_xs3_bcd_seq_dec;

    localparam int DIGITS = 4;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [4*DIGITS-1:0] in_xs3;
    logic                out_valid;
    logic                out_ready;
    logic [4*DIGITS-1:0] out_bcd;
    logic                out_err;
    logic [DIGITS-1:0]   err_mask;
    logic                busy;

    int n_pass  = 0;
    int n_total = 0;

    xs3_bcd_seq_dec #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_xs3    (in_xs3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_err   (out_err),
        .err_mask  (err_mask),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Present a word, wait (bounded) for in_ready, then pass the accept edge.
    task automatic send_word(input string tag, input logic [15:0] w);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_xs3   = w;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!in_ready) check({tag, "_accept_timeout"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid rises (bounded).
    task automatic wait_valid(input string tag);
        int lat;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            if (out_valid) begin
                lat = k - 1;
                break;
            end
            tick();
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
    endtask

    // Full transaction with out_ready held high: latency, result, one-cycle valid.
    task automatic run_word(input string tag, input logic [15:0] w,
                            input logic [15:0] exp_bcd, input logic [3:0] exp_mask);
        out_ready = 1'b1;
        send_word(tag, w);
        wait_valid(tag);
        check({tag, "_bcd"},  32'(out_bcd),  32'(exp_bcd));
        check({tag, "_mask"}, 32'(err_mask), 32'(exp_mask));
        check({tag, "_err"},  32'(out_err),  32'(exp_mask != 4'b0000));
        tick();
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic seen_valid;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_xs3    = '0;
        out_ready = 1'b0;

        // Reset state.
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_bcd",       32'(out_bcd),   32'd0);
        check("rst_mask",      32'(err_mask),  32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(in_ready),  32'd1);

        // Legal words and range limits.
        run_word("w1995", 16'h4CC8, 16'h1995, 4'b0000);
        run_word("w3333", 16'h3333, 16'h0000, 4'b0000);
        run_word("wCCCC", 16'hCCCC, 16'h9999, 4'b0000);

        // Illegal digits.
        run_word("w4CF8", 16'h4CF8, 16'h1905, 4'b0010);
        run_word("w0D21", 16'h0D21, 16'h0000, 4'b1111);

        // Backpressure: hold the result for 5 cycles with a competing input.
        out_ready = 1'b0;
        send_word("bp", 16'h4CC8);
        wait_valid("bp");
        in_valid = 1'b1;
        in_xs3   = 16'h5555;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_bcd",   32'(out_bcd),   32'h1995);
            check("bp_hold_ready", 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_ready", 32'(in_ready),  32'd1);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_retained_bcd",  32'(out_bcd),   32'h1995);
        tick();
        in_valid = 1'b0;
        check("bp2_busy", 32'(busy), 32'd1);
        wait_valid("bp2");
        check("bp2_bcd",  32'(out_bcd),  32'h2222);
        check("bp2_mask", 32'(err_mask), 32'd0);
        tick();

        // Reset during the second CONV cycle discards the word.
        send_word("mid", 16'h4CC8);
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("mid_out_valid", 32'(out_valid), 32'd0);
        check("mid_bcd",       32'(out_bcd),   32'd0);
        check("mid_busy",      32'(busy),      32'd0);
        rst = 1'b0;
        #1;
        check("mid_in_ready",  32'(in_ready),  32'd1);
        seen_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (out_valid || busy) seen_valid = 1'b1;
        end
        check("mid_no_result", 32'(seen_valid), 32'd0);

        // Reset and in_valid in the same cycle: nothing accepted.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_xs3   = 16'h4CC8;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("coll_busy",     32'(busy),     32'd0);
        check("coll_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("coll_busy_later", 32'(busy), 32'd0);

        // Decoder still functional afterwards.
        run_word("post", 16'h4CC8, 16'h1995, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
